// File: rtl/gate_stim_pkg.sv
// Shared types and constants for the gate stimulus/check stage and its benches.
package gate_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit positions of each gate function in a 6-bit result vector.
  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_XOR  = 2;
  localparam int IDX_XNOR = 3;
  localparam int IDX_NAND = 4;
  localparam int IDX_NOT  = 5;
  localparam int NUM_RES  = 6;

  localparam int NUM_VEC  = 4;

endpackage

// File: rtl/gate_stim_checker_if.sv
// Bus between the stimulus/check stage (master) and the gate block (slave).
interface gate_stim_checker_if;
  logic a_o;
  logic b_o;
  logic and_i;
  logic or_i;
  logic xor_i;
  logic xnor_i;
  logic nand_i;
  logic not_i;

  modport master (
    output a_o, b_o,
    input  and_i, or_i, xor_i, xnor_i, nand_i, not_i
  );

  modport slave (
    input  a_o, b_o,
    output and_i, or_i, xor_i, xnor_i, nand_i, not_i
  );
endinterface

// File: rtl/gate_expect.sv
// Golden combinational model of the two-input gate block.
module gate_expect
  import gate_stim_pkg::*;
(
  input  logic               a,
  input  logic               b,
  output logic [NUM_RES-1:0] exp_res
);

  // Expected value of every gate function for the current (a, b).
  always_comb begin
    exp_res           = '0;
    exp_res[IDX_AND]  = a & b;
    exp_res[IDX_OR]   = a | b;
    exp_res[IDX_XOR]  = a ^ b;
    exp_res[IDX_XNOR] = ~(a ^ b);
    exp_res[IDX_NAND] = ~(a & b);
    exp_res[IDX_NOT]  = ~a;
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Sequences the four (a,b) vectors into the gate block, holds each for
// HOLD_CYCLES, samples and checks the six results, and accumulates a
// saturating mismatch count plus a per-vector fail mask.
module gate_stim_checker
  import gate_stim_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gate_stim_checker_if.master gate,
  output logic                busy,
  output logic                done,
  output logic [1:0]          vec_idx,
  output logic                sample_stb,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [NUM_VEC-1:0]  fail_mask
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [1:0]       VEC_LAST  = 2'(NUM_VEC - 1);

  state_t               state, state_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic [PW-1:0]        pass_cnt, pass_nxt;
  logic [1:0]           vec_nxt;
  logic [ERR_W-1:0]     err_nxt;
  logic [NUM_VEC-1:0]   mask_nxt;
  logic                 a_q, b_q, a_nxt, b_nxt;
  logic                 busy_nxt, done_nxt, stb_nxt;
  logic [NUM_RES-1:0]   exp_res, got_res;
  logic                 mismatch;

  // Expected results track vec_idx, which is exactly what a_o/b_o show in DRIVE.
  gate_expect u_expect (
    .a       (vec_idx[0]),
    .b       (vec_idx[1]),
    .exp_res (exp_res)
  );

  assign gate.a_o = a_q;
  assign gate.b_o = b_q;

  // Gather the gate block results into the shared bit layout.
  always_comb begin
    got_res           = '0;
    got_res[IDX_AND]  = gate.and_i;
    got_res[IDX_OR]   = gate.or_i;
    got_res[IDX_XOR]  = gate.xor_i;
    got_res[IDX_XNOR] = gate.xnor_i;
    got_res[IDX_NAND] = gate.nand_i;
    got_res[IDX_NOT]  = gate.not_i;
    mismatch          = (got_res != exp_res);
  end

  // Next-state, counters, compare/accumulate and registered-output values.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pass_nxt  = pass_cnt;
    vec_nxt   = vec_idx;
    err_nxt   = err_cnt;
    mask_nxt  = fail_mask;
    stb_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        vec_nxt = '0;
        if (start) begin
          state_nxt = ST_DRIVE;
          hold_nxt  = '0;
          pass_nxt  = '0;
          err_nxt   = '0;
          mask_nxt  = '0;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          stb_nxt  = 1'b1;
          hold_nxt = '0;
          vec_nxt  = vec_idx + 2'd1;
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_nxt = err_cnt + ERR_W'(1);
            mask_nxt[vec_idx] = 1'b1;
          end
          if (vec_idx == VEC_LAST) begin
            pass_nxt = pass_cnt + PW'(1);
            if (pass_cnt == PASS_LAST) state_nxt = ST_DONE;
          end
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        vec_nxt   = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt == ST_DRIVE);
    done_nxt = (state_nxt == ST_DONE);
    a_nxt    = busy_nxt & vec_nxt[0];
    b_nxt    = busy_nxt & vec_nxt[1];
  end

  // State and output registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      pass_cnt   <= '0;
      vec_idx    <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_stb <= 1'b0;
      err_cnt    <= '0;
      fail_mask  <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      pass_cnt   <= pass_nxt;
      vec_idx    <= vec_nxt;
      a_q        <= a_nxt;
      b_q        <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      sample_stb <= stb_nxt;
      err_cnt    <= err_nxt;
      fail_mask  <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: two configurations, a fault-injectable gate
// block model, and a cycle-by-cycle reference built from the timing rules.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;               // 0: dut0 (H=4,P=1,W=8), 1: dut1 (H=3,P=3,W=2)
  logic [5:0] inv, s0, s1; // fault masks: invert, stuck-at-0, stuck-at-1

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_stim_checker_if ifc0();
  gate_stim_checker_if ifc1();

  logic       busy0, done0, stb0, busy1, done1, stb1;
  logic [1:0] vec0, vec1;
  logic [7:0] err0;
  logic [1:0] err1;
  logic [3:0] mask0, mask1;

  gate_stim_checker #(.HOLD_CYCLES(4), .PASSES(1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .gate(ifc0),
    .busy(busy0), .done(done0), .vec_idx(vec0), .sample_stb(stb0),
    .err_cnt(err0), .fail_mask(mask0)
  );

  gate_stim_checker #(.HOLD_CYCLES(3), .PASSES(3), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel), .gate(ifc1),
    .busy(busy1), .done(done1), .vec_idx(vec1), .sample_stb(stb1),
    .err_cnt(err1), .fail_mask(mask1)
  );

  // Ideal gate outputs from counting ones: bits and,or,xor,xnor,nand,not.
  function automatic logic [5:0] truth(input logic a, input logic b);
    int n;
    n = int'(a) + int'(b);
    return {a == 1'b0, n < 2, n != 1, n == 1, n >= 1, n == 2};
  endfunction

  function automatic logic [5:0] faulty(input logic [5:0] t, input logic [5:0] i,
                                        input logic [5:0] z, input logic [5:0] o);
    return ((t ^ i) & ~z) | o;
  endfunction

  logic [5:0] g0, g1;
  assign g0 = faulty(truth(ifc0.a_o, ifc0.b_o), inv, s0, s1);
  assign g1 = faulty(truth(ifc1.a_o, ifc1.b_o), inv, s0, s1);
  assign {ifc0.not_i, ifc0.nand_i, ifc0.xnor_i, ifc0.xor_i, ifc0.or_i, ifc0.and_i} = g0;
  assign {ifc1.not_i, ifc1.nand_i, ifc1.xnor_i, ifc1.xor_i, ifc1.or_i, ifc1.and_i} = g1;

  // Selected DUT outputs.
  logic       o_busy, o_done, o_stb, o_a, o_b;
  logic [1:0] o_vec;
  logic [7:0] o_err;
  logic [3:0] o_mask;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_stb  = sel ? stb1  : stb0;
  assign o_vec  = sel ? vec1  : vec0;
  assign o_err  = sel ? {6'd0, err1} : err0;
  assign o_mask = sel ? mask1 : mask0;
  assign o_a    = sel ? ifc1.a_o : ifc0.a_o;
  assign o_b    = sel ? ifc1.b_o : ifc0.b_o;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int busy_e, input int done_e,
                         input int vec_e, input int a_e, input int b_e,
                         input int stb_e, input int err_e, input int mask_e);
    chk({tag, " busy"}, int'(o_busy), busy_e);
    chk({tag, " done"}, int'(o_done), done_e);
    chk({tag, " vec"},  int'(o_vec),  vec_e);
    chk({tag, " a"},    int'(o_a),    a_e);
    chk({tag, " b"},    int'(o_b),    b_e);
    chk({tag, " stb"},  int'(o_stb),  stb_e);
    chk({tag, " err"},  int'(o_err),  err_e);
    chk({tag, " mask"}, int'(o_mask), mask_e);
  endtask

  // One run from a start pulse; start is toggled randomly while the run is
  // in DRIVE/DONE to confirm it is ignored. rst_at >= 1 aborts the run with
  // a reset at that edge offset.
  task automatic run(input int rst_at);
    int h, p, tot, emax, ns, e, m, v;
    bit bad [4];
    string tag;
    h    = sel ? 3 : 4;
    p    = sel ? 3 : 1;
    emax = sel ? 3 : 255;
    tot  = 4 * p * h;
    for (int k = 0; k < 4; k++) begin
      logic [5:0] t;
      t = truth(k[0], k[1]);
      bad[k] = (faulty(t, inv, s0, s1) != t);
    end
    start = 1'b1;
    for (int t = 0; t <= tot + 2; t++) begin
      @(posedge clk);
      #1;
      tag = $sformatf("sel%0d t%0d", sel, t);
      if (rst_at > 0 && t == rst_at) begin
        chk_all({tag, " rst"}, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        return;
      end
      ns = (t < tot) ? t / h : 4 * p;
      e = 0;
      m = 0;
      for (int k = 0; k < ns; k++) begin
        if (bad[k % 4]) begin
          e++;
          m |= (1 << (k % 4));
        end
      end
      if (e > emax) e = emax;
      if (t < tot) begin
        v = (t / h) % 4;
        chk_all(tag, 1, 0, v, v % 2, v / 2, int'(t >= h && t % h == 0), e, m);
      end else begin
        chk_all(tag, 0, int'(t == tot), 0, 0, 0, int'(t == tot), e, m);
      end
      if (rst_at > 0 && t + 1 == rst_at) begin
        rst   = 1'b1;
        start = 1'b0;
      end else begin
        start = (t + 1 <= tot + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  task automatic set_faults(input logic [5:0] i, input logic [5:0] z, input logic [5:0] o);
    inv = i;
    s0  = z;
    s1  = o;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    set_faults('0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset dut0", 0, 0, 0, 0, 0, 0, 0, 0);
    sel = 1'b1;
    #1;
    chk_all("reset dut1", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    sel = 1'b0;

    // Clean gate block: no mismatches, done 16 cycles after start.
    run(0);
    // and stuck at 0: only vector 3 fails.
    set_faults('0, 6'b000001, '0);
    run(0);
    // not stuck at 1 over three passes: vectors 1 and 3, count saturates at 3.
    sel = 1'b1;
    set_faults('0, '0, 6'b100000);
    run(0);
    // All results inverted: every vector fails, count saturated.
    set_faults(6'b111111, '0, '0);
    run(0);
    // Reset mid-run discards it; a following run completes normally.
    sel = 1'b0;
    set_faults(6'b000010, '0, '0);
    run(7);
    run(0);
    sel = 1'b1;
    run(10);
    run(0);

    // Randomized fault patterns on both configurations.
    for (int r = 0; r < 10; r++) begin
      sel = 1'($urandom_range(0, 1));
      set_faults(6'($urandom & $urandom), 6'($urandom & $urandom & $urandom),
                 6'($urandom & $urandom & $urandom));
      run((r % 4 == 3) ? int'($urandom_range(1, 11)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
